// File: rtl/remote_comm.sv
// Host-side UART endpoint: sends a 16-bit command as two 8N1 bytes (high byte
// first) and receives single-byte responses from the robot.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        cmd_snt,
  output logic        busy,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [7:0]    tx_shift, tx_hold;
  logic          tx_accept, tx_bit_end, tx_frame_end;

  // cmd_snt gates acceptance so a request landing on the done pulse is dropped
  assign tx_accept    = (tx_state == TX_IDLE) && snd_cmd && !cmd_snt;
  assign tx_bit_end   = (tx_state != TX_IDLE) && (tx_baud == BAUD_LAST);
  assign tx_frame_end = tx_bit_end && (tx_bit == 4'd9);

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_accept)    tx_next = TX_HIGH;
      TX_HIGH: if (tx_frame_end) tx_next = TX_LOW;
      TX_LOW:  if (tx_frame_end) tx_next = TX_IDLE;
      default:                   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // tx_bit: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_hold  <= '0;
      TX       <= 1'b1;
      busy     <= 1'b0;
      cmd_snt  <= 1'b0;
    end else begin
      cmd_snt <= 1'b0;
      if (tx_accept) begin
        tx_hold  <= cmd[7:0];
        tx_shift <= cmd[15:8];
        TX       <= 1'b0;
        busy     <= 1'b1;
        tx_baud  <= '0;
        tx_bit   <= '0;
      end else if (tx_bit_end) begin
        tx_baud <= '0;
        if (tx_frame_end) begin
          tx_bit <= '0;
          if (tx_state == TX_HIGH) begin
            tx_shift <= tx_hold;
            TX       <= 1'b0;
          end else begin
            TX      <= 1'b1;
            busy    <= 1'b0;
            cmd_snt <= 1'b1;
          end
        end else begin
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == 4'd8) begin
            TX <= 1'b1;
          end else begin
            TX       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end
      end else if (tx_state != TX_IDLE) begin
        tx_baud <= tx_baud + BAUD_ONE;
      end
    end
  end

  rx_state_t     rx_state, rx_next;
  logic          rx_ff1, rx_ff2, rx_prev;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_fall, rx_expire, rx_good;

  assign rx_fall   = rx_prev && !rx_ff2;
  assign rx_expire = (rx_state != RX_IDLE) && (rx_baud == BAUD_ONE);
  assign rx_good   = (rx_state == RX_STOP) && rx_expire && rx_ff2;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall)   rx_next = RX_START;
      RX_START: if (rx_expire) rx_next = rx_ff2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_expire && rx_bit == 4'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_expire) rx_next = RX_IDLE;
      default:                 rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1   <= 1'b1;
      rx_ff2   <= 1'b1;
      rx_prev  <= 1'b1;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      if (rx_state == RX_IDLE && rx_fall) begin
        rx_baud <= BAUD_HALF;
      end else if (rx_expire) begin
        rx_baud <= BAUD_FULL;
        if (rx_state == RX_START) begin
          rx_bit <= '0;
        end else if (rx_state == RX_DATA) begin
          rx_shift <= {rx_ff2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else if (rx_state != RX_IDLE) begin
        rx_baud <= rx_baud - BAUD_ONE;
      end
      // a good stop bit takes priority over any clear in the same cycle
      if (rx_good) begin
        resp     <= rx_shift;
        resp_rdy <= 1'b1;
      end else if (clr_resp_rdy || tx_accept) begin
        resp_rdy <= 1'b0;
      end
    end
  end

endmodule
